// File: rtl/door_seq_pkg.sv
// Shared definitions for the door sequencer: state encoding and default widths.
package door_seq_pkg;

  localparam int STATE_W       = 3;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_OPENING = 3'd1,
    ST_HOLD    = 3'd2,
    ST_CLOSING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

endpackage

// File: rtl/door_sequencer_if.sv
// Pad-side bundle of the door sequencer: requests, sensors, motor commands and status.
interface door_sequencer_if #(
  parameter int N_REQ = 4
);

  logic                             ena;
  logic [N_REQ-1:0]                 req;
  logic                             lim_open;
  logic                             lim_closed;
  logic                             obstruct;
  logic                             fault_clr;
  logic [N_REQ-1:0]                 grant;
  logic                             motor_open;
  logic                             motor_close;
  logic                             fault;
  logic [door_seq_pkg::STATE_W-1:0] state;

  modport master (
    output ena, req, lim_open, lim_closed, obstruct, fault_clr,
    input  grant, motor_open, motor_close, fault, state
  );

  modport slave (
    input  ena, req, lim_open, lim_closed, obstruct, fault_clr,
    output grant, motor_open, motor_close, fault, state
  );

endinterface

// File: rtl/door_rr_arbiter.sv
// Round-robin requester arbiter: picks the first set eff bit at or after the pointer.
module door_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] eff_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [PTR_W-1:0] ptr_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic             found_s;
  int               idx_s;

  // Scan requesters starting at the pointer and take the first one asking.
  always_comb begin
    winner_o   = '0;
    next_ptr_o = ptr_q;
    found_s    = 1'b0;
    idx_s      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = (int'(ptr_q) + k) % N_REQ;
      if (!found_s && eff_i[idx_s]) begin
        found_s          = 1'b1;
        winner_o[idx_s]  = 1'b1;
        next_ptr_o       = PTR_W'((idx_s + 1) % N_REQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves past the winner only when a grant is actually issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= next_ptr_o;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/door_sequencer.sv
// Door sequencer top: request collection, round-robin service, motor FSM and fault detection.
// Optional macro DOOR_OBSTRUCT_REVERSE_EN: obstruction reverses a closing door and extends HOLD.
module door_sequencer
  import door_seq_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int CNT_W         = CNT_W_DEFAULT,
  parameter int HOLD_CYCLES   = 1000,
  parameter int MOTOR_TIMEOUT = 5000
) (
  input logic                   clk,
  input logic                   rst,
  door_sequencer_if.slave       bus
);

  localparam int               PTR_W      = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             motor_open_q, motor_close_q, fault_q;
  logic [N_REQ-1:0] eff_s, winner_s;
  logic             advance_s, conflict_s, obstruct_rev_s;
  logic [PTR_W-1:0] ptr_unused_s, next_ptr_unused_s;

`ifdef DOOR_OBSTRUCT_REVERSE_EN
  assign obstruct_rev_s = bus.obstruct;
`else
  logic obstruct_unused_s;
  assign obstruct_unused_s = bus.obstruct;
  assign obstruct_rev_s    = 1'b0;
`endif

  assign eff_s      = pending_q | bus.req;
  assign conflict_s = bus.lim_open & bus.lim_closed;
  assign advance_s  = bus.ena & (|grant_d);
  assign pending_d  = (pending_q | bus.req) & ~grant_d;

  door_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .eff_i      (eff_s),
    .advance_i  (advance_s),
    .winner_o   (winner_s),
    .ptr_o      (ptr_unused_s),
    .next_ptr_o (next_ptr_unused_s)
  );

  // Next state, timer and grant; a limit-switch conflict overrides every state rule.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    grant_d = '0;
    if (conflict_s) begin
      state_d = ST_FAULT;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|eff_s) begin
            grant_d = winner_s;
            state_d = ST_OPENING;
            timer_d = '0;
          end else if (!bus.lim_closed) begin
            state_d = ST_CLOSING;
            timer_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_OPENING: begin
          if (bus.lim_open) begin
            state_d = ST_HOLD;
            timer_d = HOLD_LOAD;
          end else if (timer_q == MOTOR_LAST) begin
            state_d = ST_FAULT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (|eff_s) begin
            grant_d = winner_s;
            timer_d = HOLD_LOAD;
          end else if (obstruct_rev_s) begin
            timer_d = HOLD_LOAD;
          end else if (timer_q == '0) begin
            state_d = ST_CLOSING;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        ST_CLOSING: begin
          // Reversal does not grant; the request stays pending until HOLD.
          if (bus.lim_closed) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (obstruct_rev_s || (|eff_s)) begin
            state_d = ST_OPENING;
            timer_d = '0;
          end else if (timer_q == MOTOR_LAST) begin
            state_d = ST_FAULT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        ST_FAULT: begin
          if (bus.fault_clr) begin
            state_d = ST_CLOSING;
            timer_d = '0;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d = ST_FAULT;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, timer, pending and Moore outputs; ena low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      pending_q     <= '0;
      grant_q       <= '0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      fault_q       <= 1'b0;
    end else if (bus.ena) begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      motor_open_q  <= (state_d == ST_OPENING);
      motor_close_q <= (state_d == ST_CLOSING);
      fault_q       <= (state_d == ST_FAULT);
    end
  end

  assign bus.state       = state_q;
  assign bus.grant       = grant_q;
  assign bus.motor_open  = motor_open_q;
  assign bus.motor_close = motor_close_q;
  assign bus.fault       = fault_q;

endmodule
